bids22_round_ctrl: RTL and testbench
====================================

Name: bids22_round_ctrl

Overview:
- Host-side sequencer for the bids22 bid engine.
- Holds a round descriptor in a small register file, written by the host: key, three bidder balances, bidder mask, round timer and bid cost.
- On `go`, drives the engine's `C_op`/`C_data` command port through a fixed configuration sequence, then holds `C_start` for one bid round.
- Reports `done`, or a sticky error with the failing step. It replaces random `C_op` stimulus with a legal, checked command stream.

Parameters:
- DW, 32, width of `C_data` and of descriptor words.
- TIMEOUT, 1024, maximum cycles `C_start` is held before a watchdog error.

Ports:
- clk in 1: clock, rising edge.
- reset in 1: synchronous, active-high.
- wr_en in 1: descriptor register write strobe.
- wr_addr in 3: 0 key, 1 xbal, 2 ybal, 3 zbal, 4 mask (bits 2:0), 5 timer, 6 cost, 7 reserved.
- wr_data in DW: write data.
- go in 1: single-cycle start request.
- abort in 1: level; aborts the current round.
- busy out 1: sequence in progress.
- done out 1: one-cycle pulse on successful round completion.
- err out 1: sticky error flag.
- err_code out 2: 0 none, 1 engine error, 2 timeout, 3 abort.
- err_step out 4: opcode in flight when the error was taken.
- C_op out 4: engine command opcode.
- C_data out DW: engine command data.
- C_start out 1: round enable to the engine.
- eng_err in 1: engine error, valid the cycle after a command.
- eng_round_done in 1: engine round complete (level or pulse).

Behaviour:
- Reset values:
  - All outputs 0; `C_op` = NOP.
  - Descriptor registers 0; FSM in IDLE.
  - A reset mid-sequence takes effect at the next edge with no further commands issued.
- Opcodes (4-bit): NOP 0, UNLOCK 1, LOCK 2, LOAD_X 3, LOAD_Y 4, LOAD_Z 5, SET_XMASK 6, SET_TIMER 7, BID_CHARGE 8.
- Writes:
  - Accepted only when `busy` = 0; ignored while busy.
  - `wr_addr` 7 is ignored.
  - `mask` stores `wr_data[2:0]` zero-extended.
  - A write in the same cycle as `go` (while idle) is applied and used by that sequence.
- `go`:
  - Accepted only in IDLE; ignored while busy.
  - Acceptance clears `err`, `err_code` and `err_step`.
- FSM states: IDLE, ISSUE, CHECK, ROUND, FINISH.
  - IDLE --go--> ISSUE, with step = 0.
  - ISSUE: registered `C_op`/`C_data` = step entry for exactly one cycle. Next state is CHECK.
  - CHECK: `C_op` = NOP, `C_data` = 0.
    - If `eng_err` = 1: go to IDLE; `err` = 1, `err_code` = 1, `err_step` = that step's opcode.
    - Else if step = 7: go to ROUND.
    - Else: step+1 and go to ISSUE.
  - Step table:
    - 0 UNLOCK/key
    - 1 LOAD_X/xbal
    - 2 LOAD_Y/ybal
    - 3 LOAD_Z/zbal
    - 4 SET_XMASK/mask
    - 5 SET_TIMER/timer
    - 6 BID_CHARGE/cost
    - 7 LOCK/key
  - ROUND: `C_start` = 1; watchdog counts from 0.
    - On `eng_round_done`: go to FINISH.
    - On count = TIMEOUT-1 without done: go to IDLE; `err_code` = 2, `err_step` = 0.
  - FINISH: `C_start` = 0, `done` = 1 for one cycle, then go to IDLE.
- Timing (go sampled at edge 0):
  - `busy` is high from cycle 1 through the FINISH cycle inclusive.
  - UNLOCK on `C_op` in cycle 1; LOCK in cycle 15.
  - `C_start` rises in cycle 17.
  - `done` appears the cycle after `eng_round_done` is sampled.
  - Minimum go-to-done latency is 18 cycles (engine done in cycle 17).
- `abort` in ISSUE, CHECK or ROUND takes priority over `eng_err`, done and timeout in the same cycle.
  - Next cycle: IDLE, `C_start` = 0, `C_op` = NOP.
  - `err` = 1, `err_code` = 3, `err_step` = current step's opcode (0 in ROUND).
  - `abort` in IDLE has no effect.
- `eng_err` outside CHECK is ignored.
- `eng_round_done` outside ROUND is ignored.
- Watchdog counter width is `$clog2(TIMEOUT)`; it never wraps because it exits at TIMEOUT-1.
- `C_data` is 0 whenever `C_op` = NOP.

Decomposition:
- Package `bids22_ctrl_pkg` holds:
  - `opcode_e` (4-bit enum)
  - `state_e`
  - `err_code_e`
  - register address localparams
  - step count localparam (8)
- One sub-module, `bids22_watchdog`: enable/clear counter with a `timeout` pulse output, parameterised by TIMEOUT.

Test Plan:
1. Reset for 3 cycles, then idle → all outputs 0; `C_op` = 0 for 10 cycles.
2. Write key = 0xA5A5_0001, xbal = 100, ybal = 200, zbal = 300, mask = 0x5, timer = 50, cost = 3; pulse `go`; assert `eng_round_done` in cycle 20 → `C_op` sequence 1,0,3,0,4,0,5,0,6,0,7,0,8,0,2,0 with matching `C_data`; `C_start` high cycles 17–20; `done` in cycle 21; `busy` low in cycle 22.
3. Assert `eng_err` in the CHECK cycle after LOAD_Y (cycle 6) → `err` = 1, `err_code` = 1, `err_step` = 4; next `C_op` is NOP; `C_start` never rises.
4. TIMEOUT = 16 with no `eng_round_done` → `C_start` high for exactly 16 cycles, then `err_code` = 2 and `done` stays 0.
5. `abort` in cycle 9 → IDLE next cycle, `err_code` = 3, `err_step` = 6. A write to `wr_addr` 1 during `busy` is ignored; a new `go` clears `err` and reuses the old xbal.
6. `go` pulsed again while `busy`, plus `reset` asserted in cycle 12 → second `go` ignored; after reset all outputs and registers are 0, and the next sequence sends key = 0.

Source files
------------

// File: rtl/bids22_ctrl_pkg.sv
// Shared types and constants for the bids22 round controller: opcodes, FSM states,
// error codes, descriptor addresses and the fixed configuration step table.
package bids22_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP        = 4'd0,
    OP_UNLOCK     = 4'd1,
    OP_LOCK       = 4'd2,
    OP_LOAD_X     = 4'd3,
    OP_LOAD_Y     = 4'd4,
    OP_LOAD_Z     = 4'd5,
    OP_SET_XMASK  = 4'd6,
    OP_SET_TIMER  = 4'd7,
    OP_BID_CHARGE = 4'd8
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CHECK,
    ST_ROUND,
    ST_FINISH
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ENGINE  = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ABORT   = 2'd3
  } err_code_e;

  localparam logic [2:0] ADDR_KEY   = 3'd0;
  localparam logic [2:0] ADDR_XBAL  = 3'd1;
  localparam logic [2:0] ADDR_YBAL  = 3'd2;
  localparam logic [2:0] ADDR_ZBAL  = 3'd3;
  localparam logic [2:0] ADDR_MASK  = 3'd4;
  localparam logic [2:0] ADDR_TIMER = 3'd5;
  localparam logic [2:0] ADDR_COST  = 3'd6;
  localparam logic [2:0] ADDR_RSVD  = 3'd7;

  localparam int         STEP_COUNT = 8;
  localparam logic [2:0] LAST_STEP  = 3'(STEP_COUNT - 1);

  function automatic opcode_e step_op(input logic [2:0] step);
    opcode_e op;
    unique case (step)
      3'd0:    op = OP_UNLOCK;
      3'd1:    op = OP_LOAD_X;
      3'd2:    op = OP_LOAD_Y;
      3'd3:    op = OP_LOAD_Z;
      3'd4:    op = OP_SET_XMASK;
      3'd5:    op = OP_SET_TIMER;
      3'd6:    op = OP_BID_CHARGE;
      default: op = OP_LOCK;
    endcase
    return op;
  endfunction

  // Steps 0..6 read the descriptor slot of the same index; the closing LOCK re-sends the key.
  function automatic logic [2:0] step_addr(input logic [2:0] step);
    return (step == LAST_STEP) ? ADDR_KEY : step;
  endfunction

endpackage

// File: rtl/bids22_watchdog.sv
// Round watchdog: counts while enabled, clears on request, and pulses o_timeout
// on the last allowed cycle so the counter never wraps.
module bids22_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_count;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_timeout = i_en && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bids22_round_ctrl.sv
// Host-side sequencer for the bids22 engine: stores a round descriptor, issues the
// fixed checked command sequence on go, runs one watched round and reports done/err.
module bids22_round_ctrl
  import bids22_ctrl_pkg::*;
#(
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          go,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [3:0]    err_step,
  output logic [3:0]    C_op,
  output logic [DW-1:0] C_data,
  output logic          C_start,
  input  logic          eng_err,
  input  logic          eng_round_done
);

  state_e        r_state, w_state_nxt;
  logic [2:0]    r_step, w_step_nxt;
  logic [DW-1:0] r_desc [8];
  logic [DW-1:0] w_desc_nxt [8];

  logic          w_go_acc;
  logic          w_err_set;
  err_code_e     w_err_code_nxt;
  opcode_e       w_err_step_nxt;
  logic          r_err;
  err_code_e     r_err_code;
  opcode_e       r_err_step;

  opcode_e       w_c_op, r_c_op;
  logic [DW-1:0] w_c_data, r_c_data;
  logic          w_round;
  logic          w_timeout;

  assign w_round  = (r_state == ST_ROUND);
  assign w_go_acc = (r_state == ST_IDLE) && go;

  bids22_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_round),
    .i_clr    (!w_round),
    .o_timeout(w_timeout)
  );

  // Descriptor next value is computed here so a write coinciding with go feeds step 0.
  always_comb begin
    w_desc_nxt = r_desc;
    if (wr_en && (r_state == ST_IDLE) && (wr_addr != ADDR_RSVD)) begin
      if (wr_addr == ADDR_MASK) begin
        w_desc_nxt[wr_addr] = {{(DW-3){1'b0}}, wr_data[2:0]};
      end else begin
        w_desc_nxt[wr_addr] = wr_data;
      end
    end
  end

  // NOTE: the descriptor file is reset because a post-reset round must send zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_desc[i] <= '0;
    end else begin
      r_desc <= w_desc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // Abort outranks engine error, round done and timeout in every active state.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_state_nxt    = r_state;
    w_step_nxt     = r_step;
    w_err_set      = 1'b0;
    w_err_code_nxt = ERR_NONE;
    w_err_step_nxt = OP_NOP;
    unique case (r_state)
      ST_IDLE: begin
        if (go) begin
          w_state_nxt = ST_ISSUE;
          w_step_nxt  = '0;
        end
      end
      ST_ISSUE, ST_CHECK: begin
        if (abort) begin
          w_state_nxt    = ST_IDLE;
          w_err_set      = 1'b1;
          w_err_code_nxt = ERR_ABORT;
          w_err_step_nxt = step_op(r_step);
        end else if (r_state == ST_ISSUE) begin
          w_state_nxt = ST_CHECK;
        end else if (eng_err) begin
          w_state_nxt    = ST_IDLE;
          w_err_set      = 1'b1;
          w_err_code_nxt = ERR_ENGINE;
          w_err_step_nxt = step_op(r_step);
        end else if (r_step == LAST_STEP) begin
          w_state_nxt = ST_ROUND;
        end else begin
          w_state_nxt = ST_ISSUE;
          w_step_nxt  = r_step + 3'd1;
        end
      end
      ST_ROUND: begin
        if (abort) begin
          w_state_nxt    = ST_IDLE;
          w_err_set      = 1'b1;
          w_err_code_nxt = ERR_ABORT;
        end else if (eng_round_done) begin
          w_state_nxt = ST_FINISH;
        end else if (w_timeout) begin
          w_state_nxt    = ST_IDLE;
          w_err_set      = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Command port is registered from the next state so it is glitch-free toward the engine.
  always_comb begin
    w_c_op   = OP_NOP;
    w_c_data = '0;
    if (w_state_nxt == ST_ISSUE) begin
      w_c_op   = step_op(w_step_nxt);
      w_c_data = w_desc_nxt[step_addr(w_step_nxt)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c_op   <= OP_NOP;
      r_c_data <= '0;
    end else begin
      r_c_op   <= w_c_op;
      r_c_data <= w_c_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_go_acc) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_err_step <= OP_NOP;
    end else if (w_err_set) begin
      r_err      <= 1'b1;
      r_err_code <= w_err_code_nxt;
      r_err_step <= w_err_step_nxt;
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_FINISH);
  assign C_start  = w_round;
  assign C_op     = r_c_op;
  assign C_data   = r_c_data;
  assign err      = r_err;
  assign err_code = r_err_code;
  assign err_step = r_err_step;

endmodule

// File: tb/tb_bids22_round_ctrl.sv
// Directed bench for bids22_round_ctrl: reset, full round, engine error, timeout,
// abort and go/reset while busy, each with hand-derived expected values.
module tb_bids22_round_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        eng_err = 1'b0;
  logic        eng_round_done = 1'b0;
  logic        busy, done, err, C_start;
  logic [1:0]  err_code;
  logic [3:0]  err_step, C_op;
  logic [31:0] C_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [3:0]  exp_ops [8] = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
  logic [31:0] exp_d   [8] = '{32'hA5A5_0001, 32'd100, 32'd200, 32'd300,
                               32'd5, 32'd50, 32'd3, 32'hA5A5_0001};

  bids22_round_ctrl #(.DW(32), .TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .go            (go),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .err_code      (err_code),
    .err_step      (err_step),
    .C_op          (C_op),
    .C_data        (C_data),
    .C_start       (C_start),
    .eng_err       (eng_err),
    .eng_round_done(eng_round_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL tb_watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // go is sampled at edge 0; afterwards the bench sits in cycle 1.
  task automatic start_round();
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    cyc = 1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({busy, done, err, err_code, err_step, C_op, C_data, C_start} !== 45'd0) begin
        n_fail++;
        $display("FAIL reset_idle i=%0d: busy=%b done=%b err=%b code=%0d step=%0d op=%0d data=%h start=%b, want all 0",
                 i, busy, done, err, err_code, err_step, C_op, C_data, C_start);
      end
      tick();
    end
  endtask

  task automatic test_full_round();
    logic [3:0]  eo;
    logic [31:0] ed;
    wr(3'd0, 32'hA5A5_0001);
    wr(3'd1, 32'd100);
    wr(3'd2, 32'd200);
    wr(3'd3, 32'd300);
    wr(3'd4, 32'hFFFF_FFFD);
    wr(3'd5, 32'd50);
    wr(3'd7, 32'hDEAD_BEEF);
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'd3;
    start_round();
    wr_en = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_busy_c1: got %b want 1", busy);
    end
    for (int c = 1; c <= 16; c++) begin
      eo = (c % 2 == 1) ? exp_ops[(c-1)/2] : 4'd0;
      ed = (c % 2 == 1) ? exp_d[(c-1)/2]   : 32'd0;
      n_checks++;
      if (C_op !== eo || C_data !== ed || C_start !== 1'b0) begin
        n_fail++;
        $display("FAIL full_cmd c%0d: got op=%0d data=%h start=%b want op=%0d data=%h start=0",
                 c, C_op, C_data, C_start, eo, ed);
      end
      tick();
    end
    for (int c = 17; c <= 20; c++) begin
      n_checks++;
      if (C_start !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || C_op !== 4'd0) begin
        n_fail++;
        $display("FAIL full_round c%0d: got start=%b busy=%b done=%b op=%0d want 1 1 0 0",
                 c, C_start, busy, done, C_op);
      end
      if (c == 20) eng_round_done = 1'b1;
      tick();
    end
    eng_round_done = 1'b0;
    n_checks++;
    if (done !== 1'b1 || C_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_done c21: got done=%b start=%b busy=%b want 1 0 1", done, C_start, busy);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_idle c22: got busy=%b done=%b err=%b want 0 0 0", busy, done, err);
    end
  endtask

  task automatic test_engine_error();
    bit saw_start = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h0000_1234;
    start_round();
    wr_en = 1'b0;
    n_checks++;
    if (C_op !== 4'd1 || C_data !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL err_same_cycle_key: got op=%0d data=%h want 1 00001234", C_op, C_data);
    end
    goto(3);
    eng_err = 1'b1;
    tick();
    eng_err = 1'b0;
    goto(5);
    n_checks++;
    if (C_op !== 4'd4 || busy !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_ignored_in_issue c5: got op=%0d busy=%b err=%b want 4 1 0", C_op, busy, err);
    end
    tick();
    eng_err = 1'b1;
    tick();
    eng_err = 1'b0;
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'd1 || err_step !== 4'd4 || C_op !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_engine c7: got err=%b code=%0d step=%0d op=%0d busy=%b want 1 1 4 0 0",
               err, err_code, err_step, C_op, busy);
    end
    for (int i = 0; i < 20; i++) begin
      if (C_start === 1'b1) saw_start = 1'b1;
      tick();
    end
    n_checks++;
    if (saw_start !== 1'b0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_no_start: got start_seen=%b err=%b want 0 1", saw_start, err);
    end
  endtask

  task automatic test_timeout();
    int n_high = 0;
    int first  = 0;
    int last   = 0;
    bit saw_done = 1'b0;
    start_round();
    n_checks++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      n_fail++;
      $display("FAIL tmo_go_clears: got err=%b code=%0d want 0 0", err, err_code);
    end
    eng_round_done = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      if (c == 17) eng_round_done = 1'b0;
      if (C_start === 1'b1) begin
        n_high++;
        if (first == 0) first = c;
        last = c;
      end
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    n_checks++;
    if (n_high != 16 || first != 17 || last != 32) begin
      n_fail++;
      $display("FAIL tmo_start_window: got %0d cycles [%0d..%0d] want 16 [17..32]", n_high, first, last);
    end
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'd2 || err_step !== 4'd0 || saw_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_error: got err=%b code=%0d step=%0d done_seen=%b busy=%b want 1 2 0 0 0",
               err, err_code, err_step, saw_done, busy);
    end
  endtask

  task automatic test_abort();
    wr(3'd1, 32'd100);
    start_round();
    goto(3);
    wr(3'd1, 32'd999);
    goto(9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || C_op !== 4'd0 || C_start !== 1'b0 || err !== 1'b1 || err_code !== 2'd3 || err_step !== 4'd6) begin
      n_fail++;
      $display("FAIL abort_issue c10: got busy=%b op=%0d start=%b err=%b code=%0d step=%0d want 0 0 0 1 3 6",
               busy, C_op, C_start, err, err_code, err_step);
    end
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b1 || err_code !== 2'd3 || err_step !== 4'd6) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b err=%b code=%0d step=%0d want 0 1 3 6", busy, err, err_code, err_step);
    end
    start_round();
    n_checks++;
    if (err !== 1'b0 || err_code !== 2'd0 || err_step !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_go_clears: got err=%b code=%0d step=%0d want 0 0 0", err, err_code, err_step);
    end
    goto(3);
    n_checks++;
    if (C_op !== 4'd3 || C_data !== 32'd100) begin
      n_fail++;
      $display("FAIL abort_busy_write: got op=%0d data=%0d want 3 100", C_op, C_data);
    end
    goto(18);
    abort = 1'b1;
    eng_round_done = 1'b1;
    tick();
    abort = 1'b0;
    eng_round_done = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || C_start !== 1'b0 || err_code !== 2'd3 || err_step !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_round c19: got done=%b busy=%b start=%b code=%0d step=%0d want 0 0 0 3 0",
               done, busy, C_start, err_code, err_step);
    end
  endtask

  task automatic test_go_busy_reset();
    start_round();
    goto(3);
    go = 1'b1;
    tick();
    go = 1'b0;
    n_checks++;
    if (C_op !== 4'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_go c4: got op=%0d busy=%b want 0 1", C_op, busy);
    end
    tick();
    n_checks++;
    if (C_op !== 4'd4 || C_data !== 32'd200) begin
      n_fail++;
      $display("FAIL busy_go_seq c5: got op=%0d data=%0d want 4 200", C_op, C_data);
    end
    goto(12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({busy, done, err, err_code, err_step, C_op, C_data, C_start} !== 45'd0) begin
      n_fail++;
      $display("FAIL midseq_reset c13: busy=%b done=%b err=%b code=%0d step=%0d op=%0d data=%h start=%b want all 0",
               busy, done, err, err_code, err_step, C_op, C_data, C_start);
    end
    start_round();
    n_checks++;
    if (C_op !== 4'd1 || C_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_key c1: got op=%0d data=%h want 1 0", C_op, C_data);
    end
    goto(3);
    n_checks++;
    if (C_op !== 4'd3 || C_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_xbal c3: got op=%0d data=%h want 3 0", C_op, C_data);
    end
    goto(17);
    eng_round_done = 1'b1;
    tick();
    eng_round_done = 1'b0;
    n_checks++;
    if (done !== 1'b1 || C_start !== 1'b0) begin
      n_fail++;
      $display("FAIL min_latency c18: got done=%b start=%b want 1 0", done, C_start);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL min_latency_idle c19: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_full_round();
    test_engine_error();
    test_timeout();
    test_abort();
    test_go_busy_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
